// File: rtl/param_cam.sv
// Parametrised CAM: lowest-index search with multi-hit, explicit write, auto-insert, invalidate, occupancy.
// Latency 1 cycle; one op per cycle, no backpressure (priority ren > wen > ins > clr, losers dropped).
module param_cam #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ren,
  input  logic              wen,
  input  logic              ins,
  input  logic              clr,
  input  logic [DATA_W-1:0] din,
  input  logic [ADDR_W-1:0] addr,
  output logic [ADDR_W-1:0] dout,
  output logic              hit,
  output logic              multi_hit,
  output logic              ack,
  output logic              full,
  output logic [ADDR_W:0]   valid_cnt
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  valid;
  logic [DEPTH-1:0]  match;
  logic [ADDR_W-1:0] match_idx;
  logic [ADDR_W-1:0] free_idx;
  logic [ADDR_W:0]   cnt_nxt;
  logic              multi;
  logic              addr_ok;
  logic              do_wen;
  logic              do_ins;
  logic              do_clr;

  assign addr_ok = ({1'b0, addr} < DEPTH_C);
  assign do_wen  = wen && !ren;
  assign do_ins  = ins && !ren && !wen;
  assign do_clr  = clr && !ren && !wen && !ins;
  // Two or more set bits iff clearing the lowest set bit leaves something behind.
  assign multi   = |(match & (match - DEPTH'(1)));

  always_comb begin
    match     = '0;
    match_idx = '0;
    free_idx  = '0;
    cnt_nxt   = valid_cnt;
    for (int i = 0; i < DEPTH; i++) begin
      match[i] = valid[i] && (mem[i] == din);
    end
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (match[i]) match_idx = ADDR_W'(i);
      if (!valid[i]) free_idx = ADDR_W'(i);
    end
    if (do_wen && addr_ok && !valid[addr]) begin
      cnt_nxt = valid_cnt + CNT_ONE;
    end else if (do_ins && !full) begin
      cnt_nxt = valid_cnt + CNT_ONE;
    end else if (do_clr && addr_ok && valid[addr]) begin
      cnt_nxt = valid_cnt - CNT_ONE;
    end
  end

  // Data words are deliberately left out of reset; only valid bits gate matching.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (do_wen && addr_ok) begin
        mem[addr] <= din;
      end else if (do_ins && !full) begin
        mem[free_idx] <= din;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid     <= '0;
      dout      <= '0;
      hit       <= 1'b0;
      multi_hit <= 1'b0;
      ack       <= 1'b0;
      valid_cnt <= '0;
      full      <= 1'b0;
    end else begin
      ack       <= ren || wen || ins || clr;
      valid_cnt <= cnt_nxt;
      full      <= (cnt_nxt == DEPTH_C);
      if (ren) begin
        dout      <= match_idx;
        hit       <= |match;
        multi_hit <= multi;
      end else if (do_wen) begin
        dout      <= addr;
        hit       <= 1'b0;
        multi_hit <= 1'b0;
        if (addr_ok) valid[addr] <= 1'b1;
      end else if (do_ins) begin
        dout      <= full ? '0 : free_idx;
        hit       <= !full;
        multi_hit <= 1'b0;
        if (!full) valid[free_idx] <= 1'b1;
      end else if (do_clr) begin
        dout      <= addr;
        hit       <= 1'b0;
        multi_hit <= 1'b0;
        if (addr_ok) valid[addr] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_param_cam.sv
// Randomized bench for param_cam against a table-level behavioural model, plus directed literal checks.
module tb_param_cam;

  logic       clk = 1'b0;
  logic       rst, ren, wen, ins, clr;
  logic [7:0] din;
  logic [3:0] addr;
  logic [3:0] dout;
  logic       hit, multi_hit, ack, full;
  logic [4:0] valid_cnt;

  param_cam #(.DATA_W(8), .DEPTH(16), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .ren(ren), .wen(wen), .ins(ins), .clr(clr),
    .din(din), .addr(addr), .dout(dout), .hit(hit), .multi_hit(multi_hit),
    .ack(ack), .full(full), .valid_cnt(valid_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: the table as plain arrays, outputs recomputed from scratch.
  int m_data [16];
  bit m_val  [16];
  int e_dout, e_hit, e_multi, e_ack;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int occupancy();
    int n = 0;
    for (int i = 0; i < 16; i++) n += m_val[i] ? 1 : 0;
    return n;
  endfunction

  task automatic model_step(input bit r, input bit rd, input bit w, input bit in_, input bit c,
                            input int d, input int a);
    int hits, first, k;
    if (r) begin
      for (int i = 0; i < 16; i++) m_val[i] = 1'b0;
      e_dout = 0; e_hit = 0; e_multi = 0; e_ack = 0;
      return;
    end
    e_ack = (rd || w || in_ || c) ? 1 : 0;
    if (rd) begin
      hits = 0; first = -1;
      for (int i = 0; i < 16; i++)
        if (m_val[i] && m_data[i] == d) begin
          hits++;
          if (first < 0) first = i;
        end
      e_dout = (hits > 0) ? first : 0;
      e_hit = (hits > 0) ? 1 : 0;
      e_multi = (hits >= 2) ? 1 : 0;
    end else if (w) begin
      m_data[a] = d; m_val[a] = 1'b1;
      e_dout = a; e_hit = 0; e_multi = 0;
    end else if (in_) begin
      k = -1;
      for (int i = 15; i >= 0; i--) if (!m_val[i]) k = i;
      if (k >= 0) begin
        m_data[k] = d; m_val[k] = 1'b1;
        e_dout = k; e_hit = 1;
      end else begin
        e_dout = 0; e_hit = 0;
      end
      e_multi = 0;
    end else if (c) begin
      m_val[a] = 1'b0;
      e_dout = a; e_hit = 0; e_multi = 0;
    end
  endtask

  // Drive at negedge, model follows the sampling edge, everything is compared at the next negedge.
  task automatic op(input bit r, input bit rd, input bit w, input bit in_, input bit c,
                    input int d, input int a);
    rst = r; ren = rd; wen = w; ins = in_; clr = c;
    din = 8'(d); addr = 4'(a);
    @(posedge clk);
    model_step(r, rd, w, in_, c, d, a);
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("dout", int'(dout), e_dout);
      chk("hit", int'(hit), e_hit);
      chk("multi_hit", int'(multi_hit), e_multi);
      chk("ack", int'(ack), e_ack);
      chk("valid_cnt", int'(valid_cnt), occupancy());
      chk("full", int'(full), (occupancy() == 16) ? 1 : 0);
    end
  end

  initial begin
    int rd, w, in_, c;
    for (int i = 0; i < 16; i++) begin m_data[i] = 0; m_val[i] = 1'b0; end
    e_dout = 0; e_hit = 0; e_multi = 0; e_ack = 0;
    rst = 1'b1; ren = 1'b0; wen = 1'b0; ins = 1'b0; clr = 1'b0; din = '0; addr = '0;
    @(negedge clk);
    op(1, 0, 0, 0, 0, 0, 0);
    op(1, 0, 0, 0, 0, 0, 0);
    chk_en = 1'b1;

    op(0, 1, 0, 0, 0, 8'h5A, 0);
    chk("lit_empty_ack", int'(ack), 1);
    chk("lit_empty_hit", int'(hit), 0);
    chk("lit_empty_dout", int'(dout), 0);
    chk("lit_empty_cnt", int'(valid_cnt), 0);
    chk("lit_empty_full", int'(full), 0);

    op(0, 0, 1, 0, 0, 8'h5A, 3);
    op(0, 0, 1, 0, 0, 8'h5A, 9);
    op(0, 1, 0, 0, 0, 8'h5A, 0);
    chk("lit_dup_dout", int'(dout), 3);
    chk("lit_dup_hit", int'(hit), 1);
    chk("lit_dup_multi", int'(multi_hit), 1);
    chk("lit_dup_cnt", int'(valid_cnt), 2);

    op(0, 0, 0, 0, 1, 0, 3);
    op(0, 1, 0, 0, 0, 8'h5A, 0);
    chk("lit_clr_dout", int'(dout), 9);
    chk("lit_clr_hit", int'(hit), 1);
    chk("lit_clr_multi", int'(multi_hit), 0);
    chk("lit_clr_cnt", int'(valid_cnt), 1);
    op(0, 0, 0, 0, 1, 0, 3);
    chk("lit_clr2_cnt", int'(valid_cnt), 1);

    op(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      op(0, 0, 0, 1, 0, i, 0);
      chk("lit_ins_dout", int'(dout), i);
      chk("lit_ins_hit", int'(hit), 1);
      chk("lit_ins_full", int'(full), (i == 15) ? 1 : 0);
    end
    op(0, 0, 0, 1, 0, 99, 0);
    chk("lit_ins17_hit", int'(hit), 0);
    chk("lit_ins17_dout", int'(dout), 0);
    chk("lit_ins17_cnt", int'(valid_cnt), 16);

    op(0, 1, 1, 0, 0, 77, 0);
    chk("lit_renwen_hit", int'(hit), 0);
    op(0, 1, 0, 0, 0, 77, 0);
    chk("lit_renwen_later", int'(hit), 0);
    op(0, 1, 0, 0, 0, 0, 0);
    chk("lit_mem0_kept_hit", int'(hit), 1);
    chk("lit_mem0_kept_dout", int'(dout), 0);

    op(1, 0, 1, 0, 0, 8'hA5, 5);
    chk("lit_rstwen_cnt", int'(valid_cnt), 0);
    chk("lit_rstwen_ack", int'(ack), 0);
    op(0, 1, 0, 0, 0, 8'hA5, 0);
    chk("lit_rstwen_miss", int'(hit), 0);

    // Small key space and addresses keep duplicates, refills and full-table cases frequent.
    for (int n = 0; n < 3000; n++) begin
      rd = ($urandom_range(0, 3) == 0) ? 1 : 0;
      w = ($urandom_range(0, 2) == 0) ? 1 : 0;
      in_ = ($urandom_range(0, 2) == 0) ? 1 : 0;
      c = ($urandom_range(0, 3) == 0) ? 1 : 0;
      op(($urandom_range(0, 127) == 0) ? 1'b1 : 1'b0, rd[0], w[0], in_[0], c[0],
         int'($urandom_range(0, 7)), int'($urandom_range(0, 15)));
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
